// File: rtl/fifo_unpacker_pkg.sv
// Shared types and width helpers for the FIFO drain/unpack stage.
package fifo_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } unp_state_t;

  localparam int unsigned MIN_LANES = 2;

  function automatic int unsigned calc_num_lanes(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // True when the FIFO word cannot be split into whole lanes.
  function automatic bit width_mismatch(input int unsigned in_w, input int unsigned out_w);
    return (in_w % out_w) != 0;
  endfunction

  localparam bit DEFAULT_WIDTH_BAD = width_mismatch(64, 16);

endpackage

// File: rtl/fifo_unpacker_word_buf.sv
// Two-entry word buffer between the FIFO read port and the lane serializer.
module unpacker_word_buf #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_free,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_free) rd_ptr <= ~rd_ptr;
      // write and free together leave the count unchanged
      case ({wr_en, rd_free})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_unpacker.sv
// Pops 64-bit FIFO words and serializes them into OUT_WIDTH lanes on a valid/ready stream.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | popping words and emitting lanes
//   DRAIN | all words popped, emitting remaining lanes
//   DONE  | one-cycle completion pulse
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_data_out,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NUM_LANES = calc_num_lanes(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned LW        = $clog2(NUM_LANES);
  localparam logic [LW-1:0]        LANE_LAST = LW'(NUM_LANES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  if (width_mismatch(IN_WIDTH, OUT_WIDTH) || NUM_LANES < MIN_LANES) begin : g_bad_width
    $error("fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 lanes");
  end

  unp_state_t           state;
  logic [CNT_WIDTH-1:0] num_words_q;
  logic [CNT_WIDTH-1:0] words_popped;
  logic [CNT_WIDTH-1:0] words_sent;
  logic [LW-1:0]        lane_idx;
  logic                 pop_inflight;
  logic                 start_ok;
  logic                 hs;
  logic                 head_free;
  logic [IN_WIDTH-1:0]  head_data;
  logic [1:0]           occupancy;
  logic [OUT_WIDTH-1:0] lanes [NUM_LANES];

  assign start_ok = (state == ST_IDLE) && start;

  // Credit counts the word still in the FIFO read pipeline, not just buffered ones.
  assign fifo_pop = (state == ST_RUN) && !fifo_empty
                    && (({1'b0, occupancy} + {2'b00, pop_inflight}) < 3'd2)
                    && (words_popped < num_words_q);

  assign out_valid = ((state == ST_RUN) || (state == ST_DRAIN)) && (occupancy != 2'd0);
  assign hs        = out_valid && out_ready;
  assign head_free = hs && (lane_idx == LANE_LAST);
  assign out_last  = out_valid && (lane_idx == LANE_LAST) && (words_sent == num_words_q - CNT_ONE);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = head_data[g*OUT_WIDTH +: OUT_WIDTH];
  end
  assign out_data = lanes[lane_idx];

  unpacker_word_buf #(.WIDTH(IN_WIDTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (pop_inflight),
    .wr_data   (fifo_data_out),
    .rd_free   (head_free),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      num_words_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            num_words_q <= num_words;
            if (num_words != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (words_popped == num_words_q) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs && out_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_popped <= '0;
      words_sent   <= '0;
      lane_idx     <= '0;
      pop_inflight <= 1'b0;
    end else begin
      pop_inflight <= fifo_pop;
      if (start_ok) begin
        words_popped <= '0;
        words_sent   <= '0;
        lane_idx     <= '0;
      end else begin
        if (fifo_pop) words_popped <= words_popped + CNT_ONE;
        if (hs) begin
          if (lane_idx == LANE_LAST) begin
            lane_idx   <= '0;
            words_sent <= words_sent + CNT_ONE;
          end else begin
            lane_idx <= lane_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker behind a behavioural one-cycle-latency FIFO.
module tb_fifo_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic        fifo_empty = 1'b1;
  logic [63:0] fifo_data_out = '0;
  logic        fifo_pop;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  fifo_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // FIFO model: synchronous active-high reset from inverted reset, registered read data
  logic [63:0] fq[$];
  always @(posedge clk) begin
    if (!reset) begin
      fq.delete();
      fifo_data_out <= '0;
      fifo_empty    <= 1'b1;
    end else if (fifo_pop && fq.size() > 0) begin
      fifo_data_out <= fq.pop_front();
      fifo_empty    <= (fq.size() == 0);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [15:0] exp_q[$];
  logic [15:0] first4 [4];
  int n_pop, n_lane, n_last, n_valid, n_done, last_at, last_cyc, done_cyc;
  int first_pop_cyc, first_valid_cyc, words_done;
  int pop_empty_err, stall_err, occ_err, data_err;
  logic busy_at_done, prev_stall, prev_last;
  logic [15:0] prev_data;
  bit rr_en = 0;

  task automatic clear_mon();
    n_pop = 0; n_lane = 0; n_last = 0; n_valid = 0; n_done = 0;
    last_at = 0; last_cyc = 0; done_cyc = 0;
    first_pop_cyc = -1; first_valid_cyc = -1; words_done = 0;
    pop_empty_err = 0; stall_err = 0; occ_err = 0; data_err = 0;
    busy_at_done = 1'b1; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) first4[i] = '0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (fifo_pop) begin
        n_pop++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (fifo_empty) pop_empty_err++;
      end
      if (out_valid) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) data_err++;
        else if (exp_q.pop_front() !== out_data) data_err++;
        if (n_lane < 4) first4[n_lane] = out_data;
        n_lane++;
        if (n_lane % 4 == 0) words_done++;
        if (out_last) begin
          n_last++;
          last_at  = n_lane;
          last_cyc = cyc;
        end
      end
      if (n_pop - words_done > 3) occ_err++;
      if (done) begin
        n_done++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  always @(posedge clk) begin
    if (rr_en) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [63:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(w[16*i +: 16]);
  endtask

  task automatic do_start(input int n, output int t0);
    num_words = 16'(n);
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (n_done == 0 && k < limit) begin
      tick(1);
      k++;
    end
    if (n_done == 0) chk({tag, "_timeout"}, 0, 1);
    tick(2);
  endtask

  initial begin
    int t0;
    int k;
    clear_mon();
    tick(3);
    chk("rst_pop",   fifo_pop,  0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_last",  out_last,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  done,      0);
    reset = 1'b1;
    tick(2);

    // three preloaded words, always ready
    clear_mon();
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    push(64'h000c_000b_000a_0009);
    tick(1);
    do_start(3, t0);
    wait_done("t1", 100);
    chk("t1_pops",      n_pop, 3);
    chk("t1_lanes",     n_lane, 12);
    chk("t1_lane0",     first4[0], 16'h0001);
    chk("t1_lane1",     first4[1], 16'h0002);
    chk("t1_lane2",     first4[2], 16'h0003);
    chk("t1_lane3",     first4[3], 16'h0004);
    chk("t1_nlast",     n_last, 1);
    chk("t1_last_at",   last_at, 12);
    chk("t1_done_cyc",  done_cyc, last_cyc + 1);
    chk("t1_ndone",     n_done, 1);
    chk("t1_busy_done", busy_at_done, 0);
    chk("t1_first_pop", first_pop_cyc, t0 + 1);
    chk("t1_first_val", first_valid_cyc, t0 + 3);
    chk("t1_data",      data_err, 0);

    // zero-length transfer
    clear_mon();
    do_start(0, t0);
    wait_done("t2", 20);
    chk("t2_done_cyc", done_cyc, t0 + 1);
    chk("t2_pops",     n_pop, 0);
    chk("t2_valid",    n_valid, 0);
    chk("t2_ndone",    n_done, 1);

    // 64 words with random backpressure
    clear_mon();
    for (int i = 0; i < 64; i++) push({$urandom(), $urandom()});
    do_start(64, t0);
    rr_en = 1;
    wait_done("t3", 3000);
    rr_en = 0;
    tick(1);
    out_ready = 1'b1;
    chk("t3_pops",  n_pop, 64);
    chk("t3_lanes", n_lane, 256);
    chk("t3_data",  data_err, 0);
    chk("t3_stall", stall_err, 0);
    chk("t3_occ",   occ_err, 0);
    chk("t3_nlast", n_last, 1);
    chk("t3_left",  exp_q.size(), 0);

    // FIFO empty at start, data arrives 10 cycles later
    clear_mon();
    do_start(4, t0);
    tick(10);
    for (int i = 0; i < 4; i++) begin
      push(64'h1111_2222_3333_0000 + 64'(i));
      tick(1);
    end
    wait_done("t4", 200);
    chk("t4_pop_empty", pop_empty_err, 0);
    chk("t4_first_pop", first_pop_cyc, t0 + 11);
    chk("t4_pop_to_val", first_valid_cyc - first_pop_cyc, 2);
    chk("t4_lanes",     n_lane, 16);
    chk("t4_data",      data_err, 0);

    // reset mid-transfer, then a fresh two-word transfer
    clear_mon();
    for (int i = 0; i < 16; i++) push(64'habcd_0000_0000_0000 + 64'(i));
    do_start(16, t0);
    k = 0;
    while (n_lane < 5 && k < 100) begin
      tick(1);
      k++;
    end
    chk("t5_reach_lane5", n_lane >= 5, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_pop",   fifo_pop,  0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data",  out_data,  0);
    chk("t5_rst_last",  out_last,  0);
    chk("t5_rst_busy",  busy,      0);
    chk("t5_rst_done",  done,      0);
    tick(2);
    reset = 1'b1;
    tick(1);
    clear_mon();
    push(64'h0d0c_0b0a_0908_0706);
    push(64'h1514_1312_1110_0f0e);
    do_start(2, t0);
    wait_done("t5", 100);
    chk("t5_pops",  n_pop, 2);
    chk("t5_lanes", n_lane, 8);
    chk("t5_lane0", first4[0], 16'h0706);
    chk("t5_data",  data_err, 0);
    chk("t5_nlast", n_last, 1);

    // start re-pulsed during RUN must be ignored
    clear_mon();
    for (int i = 0; i < 5; i++) push(64'h5555_0000_0000_0000 + 64'(i));
    do_start(3, t0);
    tick(1);
    num_words = 16'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t6", 100);
    chk("t6_pops",     n_pop, 3);
    chk("t6_lanes",    n_lane, 12);
    chk("t6_ndone",    n_done, 1);
    chk("t6_fifo_left", fq.size(), 2);
    chk("t6_data",     data_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Drain stage that sits directly downstream of the 64-bit synchronous FIFO in the activation/weight read path. It pops full-width FIFO words, compensating for the FIFO's registered one-cycle read latency. It serializes each word into `IN_WIDTH/OUT_WIDTH` lanes on a valid/ready stream feeding the PE array input, and stops after a programmed number of words.

## Interface
- `IN_WIDTH`, 64: FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 16: output lane width; `NUM_LANES = IN_WIDTH/OUT_WIDTH`, at least 2.
- `CNT_WIDTH`, 16: width of the word-count field.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse, sampled only in IDLE.
- `num_words`  in  CNT_WIDTH  words to transfer, latched on `start`.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data_out`  in  IN_WIDTH  FIFO `data_out`, valid the cycle after a pop.
- `fifo_pop`  out  1  FIFO `pop`.
- `out_valid`  out  1  lane valid.
- `out_ready`  in  1  downstream ready.
- `out_data`  out  OUT_WIDTH  current lane.
- `out_last`  out  1  final lane of the final word.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at completion.

## Operation
- One clock; reset is asynchronous and active-low.
- Reset (`reset`=0), asynchronous: all of the following are cleared.
  - Outputs: `fifo_pop`, `out_valid`, `out_data`, `out_last`, `busy`, `done` go to 0.
  - State: FSM goes to IDLE; counters, buffer and in-flight flag are cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` with `num_words`≠0.
  - IDLE → DONE on `start` with `num_words`=0.
  - RUN → DRAIN once `words_popped == num_words`.
  - DRAIN → DONE when the last lane handshakes (`out_valid & out_ready & out_last`).
  - DONE → IDLE unconditionally after 1 cycle; `done`=1 only in DONE.
- Word buffer: 2 entries. `pop_inflight` is a register set the cycle `fifo_pop`=1.
- `fifo_pop = (state==RUN) & !fifo_empty & (occupancy + pop_inflight < 2) & (words_popped < num_words)`.
  - `fifo_pop` is never asserted when the FIFO is empty; pops never exceed `num_words`.
  - `fifo_pop` is combinational from registered state and `fifo_empty`.
- The cycle after a pop, `fifo_data_out` is written into the buffer tail.
- Lane order: lane 0 = bits `[OUT_WIDTH-1:0]` first, ascending.
- `out_data` is taken from the head entry selected by `lane_idx`.
- On a handshake (`out_valid & out_ready`):
  - `lane_idx` increments.
  - At `NUM_LANES-1`, `lane_idx` wraps to 0, the head entry is freed and `words_sent` increments.
- `out_last = out_valid & (lane_idx == NUM_LANES-1) & (words_sent == num_words-1)`.
- Backpressure: when `out_valid=1` and `out_ready=0`, `out_data` and `out_last` hold stable. Pops continue only while buffer credit remains.
- Simultaneous buffer write and head free in the same cycle: occupancy is unchanged.
- `start` while not in IDLE is ignored.
- Reset mid-transfer drops buffered and in-flight data. The FIFO is reset with the same reset, so nothing is left stranded.
- Counters are `CNT_WIDTH` bits; `num_words` may be at most `2^CNT_WIDTH - 1`.

## Timing
- `start` at cycle t0: earliest `fifo_pop` at t0+1.
- `fifo_data_out` is valid at t0+2 and written at the end of t0+2; earliest `out_valid` is at t0+3.
- Steady state, with `out_ready`=1 and the FIFO non-empty: one lane per cycle, no bubbles between words. The 2-entry buffer covers the 1-cycle read latency because `NUM_LANES`≥2.
- `done` pulses the cycle after the `out_last` handshake; `busy` falls the same cycle `done` rises.
- `num_words`=0: `done` at t0+1, with no pop and no `out_valid`.

## Structure
- Package `fifo_unpacker_pkg`:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - `NUM_LANES` computation.
  - Width-check constant that flags `IN_WIDTH % OUT_WIDTH != 0`.
- Sub-module `unpacker_word_buf`: 2-entry word buffer.
  - Ports: `wr_en`, `wr_data`, `rd_free`, `head_data`, `occupancy[1:0]`.
  - Same clock and asynchronous active-low reset as the parent.
- Top level: FSM, pop/credit logic, lane mux, counters.
- Instantiated behind the FIFO in the bench; the FIFO's synchronous active-high reset is driven from inverted `reset`.

## Test plan
- Reset, `start` with `num_words`=3, FIFO preloaded with 3 words, `out_ready`=1:
  - exactly 3 pops and 12 lanes emitted;
  - word 0x0004_0003_0002_0001 yields lanes 0x0001, 0x0002, 0x0003, 0x0004;
  - `out_last` only on lane 12; `done` one cycle later.
- `num_words`=0 → `done` at t0+1, with `fifo_pop` and `out_valid` never high.
- Random `out_ready` (50%) over 64 words: `out_data` stable while stalled; at most 2 words buffered plus 1 in flight; lane sequence matches the pushed data exactly.
- FIFO empty at start, pushes begin 10 cycles later: no pop while `fifo_empty`=1; first `out_valid` 2 cycles after the first pop.
- Reset asserted mid-transfer (after lane 5 of 16):
  - all outputs go to 0 immediately (asynchronous);
  - a new `start` with `num_words`=2 after fresh FIFO pushes completes correctly.
- `start` pulsed during RUN: ignored; the original count completes with no extra pop.
